// File: rtl/video_pkg.sv
// Shared types and helpers for the SFP video path: FSM states, RGB565 expansion, blank colour.
package video_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StReq,
        StPrime,
        StRun
    } state_e;

    localparam logic [23:0] BlankRgbDefault = 24'h000000;

    // Replicate MSBs into the vacated LSBs so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = px[15:11];
        g = px[10:5];
        b = px[4:0];
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
    endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Polarity-corrected leading-edge detector for vertical sync; emits a one-cycle frame-start pulse.
module vsync_edge_det #(
    parameter bit VsPol = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vs_i,
    output logic fs_o
);

    logic vs_act;
    logic vs_act_q;

    assign vs_act = VsPol ? vs_i : ~vs_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_act_q <= 1'b0;
        end else begin
            vs_act_q <= vs_act;
        end
    end

    assign fs_o = vs_act & ~vs_act_q;

endmodule

// File: rtl/fifo_pixel_reader.sv
// Pixel-clock read side of the width-converting video FIFO: per-frame flush/request/prime,
// then one RGB565 pop per active cycle, expanded to timing-aligned RGB888 with underflow tracking.
module fifo_pixel_reader
    import video_pkg::*;
#(
    parameter bit          VS_POL       = 1'b1,
    parameter int unsigned FLUSH_CYCLES = 16,
    parameter int unsigned PRIME_LEVEL  = 512,
    parameter int unsigned LEVEL_W      = 13,
    parameter logic [23:0] BLANK_RGB    = BlankRgbDefault
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               vs_in,
    input  logic               hs_in,
    input  logic               de_in,
    output logic               rd_en,
    input  logic [15:0]        rd_data,
    input  logic               rd_empty,
    input  logic [LEVEL_W-1:0] rd_water_level,
    output logic               fifo_flush,
    output logic               frame_req,
    output logic               vs_out,
    output logic               hs_out,
    output logic               de_out,
    output logic [23:0]        rgb_out,
    output logic               underflow_flag,
    output logic [15:0]        underflow_cnt,
    output logic [10:0]        line_cnt
);

    localparam logic [7:0] FlushLast = 8'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;
    logic        fifo_flush_q, frame_req_q;
    logic        vs_q, hs_q, de_q, pop_q;
    logic        uf_flag_q, uf_flag_d;
    logic [15:0] uf_cnt_q, uf_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;

    logic        fs;
    logic        prime_ok;
    logic        rd_en_int;
    logic        uf_pixel;
    logic        de_fall;

    vsync_edge_det #(
        .VsPol (VS_POL)
    ) u_vsync_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .vs_i  (vs_in),
        .fs_o  (fs)
    );

    // Unsigned, zero-extended compare: a nearly-full FIFO must never look empty.
    assign prime_ok = 32'(rd_water_level) >= PRIME_LEVEL;

    assign rd_en_int = (state_q == StRun) & de_in & ~rd_empty & ~fifo_flush_q;
    assign uf_pixel  = de_in & ((state_q == StPrime) | (state_q == StRun)) & ~rd_en_int;
    assign de_fall   = de_q & ~de_in;

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = StIdle;
        end else if (fs) begin
            state_d = StFlush;
        end else begin
            case (state_q)
                StFlush: if (flush_cnt_q == FlushLast) state_d = StReq;
                StReq:   state_d = StPrime;
                StPrime: if (prime_ok) state_d = StRun;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        flush_cnt_d = 8'd0;
        if (state_q == StFlush && state_d == StFlush && !fs) begin
            flush_cnt_d = flush_cnt_q + 8'd1;
        end

        // An underflow coinciding with frame start keeps the flag set.
        uf_flag_d = uf_flag_q;
        if (uf_pixel) begin
            uf_flag_d = 1'b1;
        end else if (fs) begin
            uf_flag_d = 1'b0;
        end

        uf_cnt_d = uf_cnt_q;
        if (uf_pixel && uf_cnt_q != 16'hFFFF) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end

        line_cnt_d = line_cnt_q;
        if (fs) begin
            line_cnt_d = 11'd0;
        end else if (de_fall && state_q != StIdle) begin
            line_cnt_d = line_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            flush_cnt_q  <= 8'd0;
            fifo_flush_q <= 1'b0;
            frame_req_q  <= 1'b0;
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            de_q         <= 1'b0;
            pop_q        <= 1'b0;
            uf_flag_q    <= 1'b0;
            uf_cnt_q     <= 16'd0;
            line_cnt_q   <= 11'd0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            fifo_flush_q <= (state_d == StFlush);
            frame_req_q  <= (state_d == StReq);
            vs_q         <= vs_in;
            hs_q         <= hs_in;
            de_q         <= de_in;
            pop_q        <= rd_en_int;
            uf_flag_q    <= uf_flag_d;
            uf_cnt_q     <= uf_cnt_d;
            line_cnt_q   <= line_cnt_d;
        end
    end

    assign rd_en          = rd_en_int;
    assign fifo_flush     = fifo_flush_q;
    assign frame_req      = frame_req_q;
    assign vs_out         = vs_q;
    assign hs_out         = hs_q;
    assign de_out         = de_q;
    assign rgb_out        = (pop_q && de_q) ? rgb565_to_888(rd_data) : BLANK_RGB;
    assign underflow_flag = uf_flag_q;
    assign underflow_cnt  = uf_cnt_q;
    assign line_cnt       = line_cnt_q;

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Self-checking bench for fifo_pixel_reader: FIFO model, RGB scoreboard, vector table, corner cases.
module tb_fifo_pixel_reader;
    import video_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, en, vs_in, hs_in, de_in, rd_empty;
    logic [15:0] rd_data = 16'h0000;
    logic [12:0] rd_water_level;
    logic        rd_en, fifo_flush, frame_req, vs_out, hs_out, de_out, underflow_flag;
    logic [23:0] rgb_out;
    logic [15:0] underflow_cnt;
    logic [10:0] line_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] fifo[$];
    logic [23:0] sb[$];
    logic        force_empty;

    typedef struct {
        logic [15:0] word;
        logic [23:0] rgb;
    } vec_t;
    vec_t vecs[8];

    fifo_pixel_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .vs_in          (vs_in),
        .hs_in          (hs_in),
        .de_in          (de_in),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .fifo_flush     (fifo_flush),
        .frame_req      (frame_req),
        .vs_out         (vs_out),
        .hs_out         (hs_out),
        .de_out         (de_out),
        .rgb_out        (rgb_out),
        .underflow_flag (underflow_flag),
        .underflow_cnt  (underflow_cnt),
        .line_cnt       (line_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO read port: data appears the cycle after the pop.
    always @(posedge clk) begin
        if (rd_en === 1'b1 && fifo.size() > 0) rd_data <= fifo.pop_front();
    end

    always @(negedge clk) begin
        if (rd_en === 1'b1) check("no_pop_when_empty", 32'(rd_empty), 0);
        if (de_out === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) check("rgb_out", 32'(rgb_out), 32'(sb.pop_front()));
        end else begin
            check("rgb_blank_no_de", 32'(rgb_out), 0);
        end
    end

    task automatic pixel(input logic d, input logic exp_pop, input logic [23:0] exp_rgb);
        de_in    = d;
        rd_empty = force_empty || (fifo.size() == 0);
        #1;
        check("rd_en", 32'(rd_en), 32'(exp_pop));
        if (d) sb.push_back(exp_rgb);
        tick();
    endtask

    task automatic start_frame();
        int n = 0;
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        check("vs_out_delay", 32'(vs_out), 1);
        check("flush_after_fs", 32'(fifo_flush), 1);
        while (fifo_flush === 1'b1 && n < 64) begin
            n++;
            check("no_req_in_flush", 32'(frame_req), 0);
            tick();
        end
        check("flush_len", 32'(n), 16);
        check("frame_req_pulse", 32'(frame_req), 1);
        tick();
        check("frame_req_one_cycle", 32'(frame_req), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hF800, 24'hFF0000};
        vecs[1] = '{16'h07E0, 24'h00FF00};
        vecs[2] = '{16'h001F, 24'h0000FF};
        vecs[3] = '{16'hFFFF, 24'hFFFFFF};
        vecs[4] = '{16'h0000, 24'h000000};
        vecs[5] = '{16'h8410, 24'h848284};
        vecs[6] = '{16'h0841, 24'h080808};
        vecs[7] = '{16'h7BEF, 24'h7B7D7B};

        rst_n = 1'b0; en = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
        rd_empty = 1'b1; force_empty = 1'b0; rd_water_level = 13'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_flush", 32'(fifo_flush), 0);
        check("rst_frame_req", 32'(frame_req), 0);
        check("rst_uf_flag", 32'(underflow_flag), 0);
        check("rst_uf_cnt", 32'(underflow_cnt), 0);
        check("rst_line_cnt", 32'(line_cnt), 0);
        check("rst_de_out", 32'(de_out), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick();

        // Idle: active video without a frame start is blank and uncounted
        repeat (4) pixel(1'b1, 1'b0, 24'h000000);
        pixel(1'b0, 1'b0, 24'h000000);
        check("idle_uf_cnt", 32'(underflow_cnt), 0);
        check("idle_line_cnt", 32'(line_cnt), 0);
        check("idle_state", 32'(dut.state_q), 32'(StIdle));
        hs_in = 1'b1;
        tick();
        hs_in = 1'b0;
        check("hs_out_high", 32'(hs_out), 1);
        tick();
        check("hs_out_low", 32'(hs_out), 0);

        // Second fs mid-flush must restart the full flush count
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        repeat (4) tick();
        check("flush_mid", 32'(fifo_flush), 1);
        start_frame();

        rd_water_level = 13'd511;
        repeat (4) begin
            check("state_prime", 32'(dut.state_q), 32'(StPrime));
            pixel(1'b0, 1'b0, 24'h000000);
        end
        rd_water_level = 13'd512;
        tick();
        check("state_run", 32'(dut.state_q), 32'(StRun));

        repeat (1920) fifo.push_back(16'hF800);
        repeat (1920) pixel(1'b1, 1'b1, 24'hFF0000);
        pixel(1'b0, 1'b0, 24'h000000);
        check("line1_cnt", 32'(line_cnt), 1);
        check("line1_uf_cnt", 32'(underflow_cnt), 0);
        check("line1_uf_flag", 32'(underflow_flag), 0);

        foreach (vecs[i]) fifo.push_back(vecs[i].word);
        foreach (vecs[i]) pixel(1'b1, 1'b1, vecs[i].rgb);
        pixel(1'b0, 1'b0, 24'h000000);
        check("line2_cnt", 32'(line_cnt), 2);

        repeat (15) fifo.push_back(16'h001F);
        repeat (7) pixel(1'b1, 1'b1, 24'h0000FF);
        force_empty = 1'b1;
        repeat (5) pixel(1'b1, 1'b0, 24'h000000);
        force_empty = 1'b0;
        repeat (8) pixel(1'b1, 1'b1, 24'h0000FF);
        pixel(1'b0, 1'b0, 24'h000000);
        check("uf_flag_set", 32'(underflow_flag), 1);
        check("uf_cnt_5", 32'(underflow_cnt), 5);
        check("line3_cnt", 32'(line_cnt), 3);

        // fs while running: restart, flag and line count cleared, total kept
        start_frame();
        check("fs_clears_flag", 32'(underflow_flag), 0);
        check("fs_keeps_cnt", 32'(underflow_cnt), 5);
        check("fs_clears_line", 32'(line_cnt), 0);
        tick();
        check("rerun_state", 32'(dut.state_q), 32'(StRun));

        repeat (4) fifo.push_back(16'h07E0);
        repeat (3) pixel(1'b1, 1'b1, 24'h00FF00);
        en = 1'b0;
        pixel(1'b1, 1'b1, 24'h00FF00);
        check("en_drop_idle", 32'(dut.state_q), 32'(StIdle));
        pixel(1'b1, 1'b0, 24'h000000);
        pixel(1'b0, 1'b0, 24'h000000);
        check("en_drop_uf_cnt", 32'(underflow_cnt), 5);
        check("en_drop_line", 32'(line_cnt), 0);

        en    = 1'b1;
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        repeat (2) tick();
        check("flush_before_rst", 32'(fifo_flush), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_flush", 32'(fifo_flush), 0);
        check("async_rst_uf_cnt", 32'(underflow_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_state", 32'(dut.state_q), 32'(StIdle));

        start_frame();
        tick();
        check("sat_run", 32'(dut.state_q), 32'(StRun));
        force_empty = 1'b1;
        repeat (65534) pixel(1'b1, 1'b0, 24'h000000);
        pixel(1'b0, 1'b0, 24'h000000);
        check("uf_cnt_fffe", 32'(underflow_cnt), 32'hFFFE);
        repeat (3) pixel(1'b1, 1'b0, 24'h000000);
        pixel(1'b0, 1'b0, 24'h000000);
        check("uf_cnt_sat", 32'(underflow_cnt), 32'hFFFF);

        // Underflow in the same cycle as fs: set beats clear
        vs_in = 1'b1;
        pixel(1'b1, 1'b0, 24'h000000);
        vs_in = 1'b0;
        check("uf_set_wins", 32'(underflow_flag), 1);
        check("uf_cnt_hold", 32'(underflow_cnt), 32'hFFFF);
        check("fs_uf_flush", 32'(fifo_flush), 1);
        force_empty = 1'b0;
        pixel(1'b0, 1'b0, 24'h000000);
        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
